// File: rtl/mips_run_ctrl.sv
// Run controller and result monitor for a simulated MIPS core: sequences core reset,
// counts RUN cycles and GPR writes, detects halt/timeout and freezes a write signature.
module mips_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 5,
    parameter int unsigned MAX_CYCLES   = 2048,
    parameter logic [31:0] HALT_INSTR   = 32'h1000_ffff,
    parameter int unsigned HALT_STABLE  = 4,
    parameter int unsigned CNT_W        = 32,
    parameter logic [31:0] SIG_SEED     = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             grf_we,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wdata,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [31:0]      signature,
    output logic [31:0]      halt_pc
);

    typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_DONE} state_t;

    // A RESET_CYCLES of 0 still holds the core for one edge.
    localparam logic [31:0]      HOLD_LAST = (RESET_CYCLES == 0) ? 32'd0 : 32'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES);
    localparam logic [31:0]      STABLE_N  = 32'(HALT_STABLE);

    state_t           state_q, state_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [31:0]      signature_q, signature_d;
    logic [31:0]      halt_pc_q, halt_pc_d;
    logic [31:0]      hold_q, hold_d;
    logic [31:0]      stable_q, stable_d;
    logic [31:0]      pc_prev_q, pc_prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             halt_hit;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d      = state_q;
        cpu_reset_d  = cpu_reset_q;
        running_d    = running_q;
        done_d       = done_q;
        halted_d     = halted_q;
        timeout_d    = timeout_q;
        cycle_cnt_d  = cycle_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        signature_d  = signature_q;
        halt_pc_d    = halt_pc_q;
        hold_d       = hold_q;
        stable_d     = stable_q;
        pc_prev_d    = pc_prev_q;
        prev_valid_d = prev_valid_q;
        halt_hit     = 1'b0;

        case (state_q)
            ST_HOLD: begin
                hold_d = hold_q + 32'd1;
                if (hold_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    cpu_reset_d = 1'b0;
                    running_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + 1'b1;
                if (grf_we && grf_addr != 5'd0) begin
                    if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
                    signature_d = {signature_q[30:0], signature_q[31]} ^ grf_wdata ^ {27'b0, grf_addr};
                end
                if (prev_valid_q && pc == pc_prev_q) begin
                    if (stable_q != 32'hffff_ffff) stable_d = stable_q + 32'd1;
                end else begin
                    stable_d = 32'd0;
                end
                pc_prev_d    = pc;
                prev_valid_d = 1'b1;

                // Halt takes priority over a timeout landing on the same edge.
                halt_hit = (instr == HALT_INSTR) || (HALT_STABLE != 0 && stable_d == STABLE_N);
                if (halt_hit || cycle_cnt_d == CYC_LIMIT) begin
                    state_d     = ST_DONE;
                    cpu_reset_d = 1'b1;
                    running_d   = 1'b0;
                    done_d      = 1'b1;
                    if (halt_hit) begin
                        halted_d  = 1'b1;
                        halt_pc_d = pc;
                    end else begin
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_DONE: ;
            default: state_d = ST_HOLD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HOLD;
            cpu_reset_q  <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            cycle_cnt_q  <= '0;
            wr_cnt_q     <= '0;
            signature_q  <= SIG_SEED;
            halt_pc_q    <= 32'd0;
            hold_q       <= 32'd0;
            stable_q     <= 32'd0;
            pc_prev_q    <= 32'd0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_reset_q  <= cpu_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            cycle_cnt_q  <= cycle_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            signature_q  <= signature_d;
            halt_pc_q    <= halt_pc_d;
            hold_q       <= hold_d;
            stable_q     <= stable_d;
            pc_prev_q    <= pc_prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign running   = running_q;
    assign done      = done_q;
    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign signature = signature_q;
    assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: two instances with different parameters, one driven at a time;
// a reference model pushes expected outputs per edge and the scoreboard pops and compares.
module tb_mips_run_ctrl;

    localparam logic [31:0] HALT = 32'h1000_ffff;

    typedef struct packed {
        logic        cpu_reset;
        logic        running;
        logic        done;
        logic        halted;
        logic        timeout;
        logic [31:0] cycle;
        logic [31:0] wr;
        logic [31:0] sig;
        logic [31:0] hpc;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_a = 1'b0, reset_b = 1'b0;
    logic [31:0] pc = '0, instr = '0, grf_wdata = '0;
    logic        grf_we = 1'b0;
    logic [4:0]  grf_addr = '0;

    logic        a_cr, a_run, a_done, a_halt, a_to, b_cr, b_run, b_done, b_halt, b_to;
    logic [31:0] a_cyc, a_wr, a_sig, a_hpc, b_cyc, b_wr, b_sig, b_hpc;
    obs_t        obs_a, obs_b;

    int checks = 0, failures = 0;
    obs_t sb_q[$];

    // reference model state
    logic        m_run, m_done, m_halted, m_timeout, m_pv;
    logic [31:0] m_cycle, m_wr, m_sig, m_hpc, m_stable, m_pcprev;

    always #5 clk = ~clk;

    mips_run_ctrl #(.RESET_CYCLES(5), .MAX_CYCLES(2048), .HALT_STABLE(4)) u_a (
        .clk(clk), .reset(reset_a), .pc(pc), .instr(instr), .grf_we(grf_we),
        .grf_addr(grf_addr), .grf_wdata(grf_wdata), .cpu_reset(a_cr), .running(a_run),
        .done(a_done), .halted(a_halt), .timeout(a_to), .cycle_cnt(a_cyc), .wr_cnt(a_wr),
        .signature(a_sig), .halt_pc(a_hpc));

    mips_run_ctrl #(.RESET_CYCLES(0), .MAX_CYCLES(16), .HALT_STABLE(0)) u_b (
        .clk(clk), .reset(reset_b), .pc(pc), .instr(instr), .grf_we(grf_we),
        .grf_addr(grf_addr), .grf_wdata(grf_wdata), .cpu_reset(b_cr), .running(b_run),
        .done(b_done), .halted(b_halt), .timeout(b_to), .cycle_cnt(b_cyc), .wr_cnt(b_wr),
        .signature(b_sig), .halt_pc(b_hpc));

    assign obs_a = {a_cr, a_run, a_done, a_halt, a_to, a_cyc, a_wr, a_sig, a_hpc};
    assign obs_b = {b_cr, b_run, b_done, b_halt, b_to, b_cyc, b_wr, b_sig, b_hpc};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        check({tag, ".cpu_reset"}, 32'(o.cpu_reset), 32'(e.cpu_reset));
        check({tag, ".running"},   32'(o.running),   32'(e.running));
        check({tag, ".done"},      32'(o.done),      32'(e.done));
        check({tag, ".halted"},    32'(o.halted),    32'(e.halted));
        check({tag, ".timeout"},   32'(o.timeout),   32'(e.timeout));
        check({tag, ".cycle_cnt"}, o.cycle, e.cycle);
        check({tag, ".wr_cnt"},    o.wr,    e.wr);
        check({tag, ".signature"}, o.sig,   e.sig);
        check({tag, ".halt_pc"},   o.hpc,   e.hpc);
    endtask

    function automatic obs_t model_exp();
        obs_t e;
        e.cpu_reset = !m_run;
        e.running   = m_run;
        e.done      = m_done;
        e.halted    = m_halted;
        e.timeout   = m_timeout;
        e.cycle     = m_cycle;
        e.wr        = m_wr;
        e.sig       = m_sig;
        e.hpc       = m_hpc;
        return e;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_halted = 0; m_timeout = 0; m_pv = 0;
        m_cycle = 0; m_wr = 0; m_sig = 32'h0; m_hpc = 0; m_stable = 0; m_pcprev = 0;
    endtask

    function automatic obs_t dut_obs(input int sel);
        return (sel == 0) ? obs_a : obs_b;
    endfunction

    task automatic set_reset(input int sel, input logic v);
        if (sel == 0) reset_a = v; else reset_b = v;
    endtask

    // Assert reset away from any edge and check that outputs clear at once.
    task automatic pulse_reset(input int sel, input string tag);
        @(posedge clk);
        #3 set_reset(sel, 1'b0);
        model_reset();
        #1 compare(tag, dut_obs(sel), model_exp());
    endtask

    // Release reset at a falling edge, then check each HOLD edge up to entry into RUN.
    task automatic hold_seq(input int sel, input int n, input string tag);
        @(negedge clk);
        set_reset(sel, 1'b1);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            m_run = (e == n);
            compare($sformatf("%s.edge%0d", tag, e), dut_obs(sel), model_exp());
        end
    endtask

    task automatic step(input int sel, input logic [31:0] p, input logic [31:0] ins,
                        input logic we, input logic [4:0] ad, input logic [31:0] wd,
                        input string tag);
        obs_t e;
        int unsigned max_c = (sel == 0) ? 2048 : 16;
        int unsigned hs    = (sel == 0) ? 4 : 0;
        @(negedge clk);
        pc = p; instr = ins; grf_we = we; grf_addr = ad; grf_wdata = wd;
        if (m_run) begin
            m_cycle++;
            if (we && ad != 0) begin
                m_wr++;
                m_sig = {m_sig[30:0], m_sig[31]} ^ wd ^ {27'b0, ad};
            end
            m_stable = (m_pv && p == m_pcprev) ? m_stable + 1 : 0;
            m_pcprev = p;
            m_pv = 1;
            if (ins == HALT || (hs != 0 && m_stable == hs)) begin
                m_run = 0; m_done = 1; m_halted = 1; m_hpc = p;
            end else if (m_cycle == max_c) begin
                m_run = 0; m_done = 1; m_timeout = 1;
            end
        end
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare(tag, dut_obs(sel), e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare("rst_a", obs_a, model_exp());
        compare("rst_b", obs_b, model_exp());

        // Instance A: 5-edge HOLD, then signature run halted by HALT_INSTR on cycle 37.
        hold_seq(0, 5, "hold_a");
        step(0, 32'h3000, 32'h3c01_0000, 1'b1, 5'd1, 32'h1,         "sig1");
        step(0, 32'h3004, 32'h3c01_0001, 1'b1, 5'd2, 32'h2,         "sig2");
        step(0, 32'h3008, 32'h3c01_0002, 1'b1, 5'd0, 32'hffff_ffff, "sig0");
        for (int i = 4; i <= 36; i++)
            step(0, 32'h3000 + 32'(4 * (i - 1)), 32'h2408_0000 + 32'(i),
                 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom,
                 $sformatf("run%0d", i));
        step(0, 32'h3010, HALT, 1'b1, 5'd7, 32'hcafe_f00d, "halt37");
        for (int i = 0; i < 3; i++)
            step(0, 32'h3100 + 32'(4 * i), HALT, 1'b1, 5'd9, 32'h1234_5678,
                 $sformatf("frozen_a%0d", i));

        // Reset from DONE, replay HOLD, then reset mid-RUN and replay again.
        pulse_reset(0, "rst_done_a");
        hold_seq(0, 5, "hold_a2");
        for (int i = 0; i < 4; i++)
            step(0, 32'h4000 + 32'(4 * i), 32'h0, 1'b1, 5'(i + 3), 32'h0f0f_0000 + 32'(i),
                 $sformatf("mid%0d", i));
        pulse_reset(0, "rst_mid_a");
        hold_seq(0, 5, "hold_a3");

        // PC stuck: halt on the 5th edge at the same PC.
        step(0, 32'h3000, 32'h0, 1'b0, 5'd0, 32'h0, "stk0");
        for (int i = 1; i <= 5; i++)
            step(0, 32'h3008, 32'h0, 1'b1, 5'd4, 32'h1000 + 32'(i), $sformatf("stk%0d", i));
        step(0, 32'h3008, 32'h0, 1'b1, 5'd4, 32'h5555, "stk_frozen");
        reset_a = 1'b0;

        // Instance B: 1-edge HOLD, stuck PC with stability detection off runs to timeout.
        model_reset();
        hold_seq(1, 1, "hold_b");
        for (int i = 1; i <= 16; i++)
            step(1, 32'h3008, 32'h0, 1'(i % 3 == 0), 5'(i), 32'(i * 17), $sformatf("to%0d", i));
        step(1, 32'h3008, HALT, 1'b1, 5'd1, 32'h1, "to_frozen");

        // HALT_INSTR on the budget edge: halt wins over timeout.
        pulse_reset(1, "rst_b");
        hold_seq(1, 1, "hold_b2");
        for (int i = 1; i <= 15; i++)
            step(1, 32'h3000 + 32'(4 * i), 32'h0, 1'b1, 5'd2, 32'(i), $sformatf("ht%0d", i));
        step(1, 32'h3100, HALT, 1'b1, 5'd3, 32'habcd, "ht16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
